// File: rtl/segasys1_sound_cmd.sv
// Sound-CPU side of the main->sound command path: synchronised request capture,
// a small command FIFO, and an edge-per-command NMI generator with an enforced low gap.
// state  | meaning
// IDLE   | no command outstanding, SNMI low
// ASSERT | command at FIFO head, SNMI high until the sound CPU pops it
// GAP    | SNMI held low for NMI_GAP cycles so the next NMI is a fresh edge
module segasys1_sound_cmd #(
  parameter int DEPTH_LOG2  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int NMI_GAP     = 16
) (
  input  logic       CLK48M,
  input  logic       RESET_N,
  input  logic       SNDRQ,
  input  logic [7:0] CMDIN,
  input  logic       SCPU_RD,
  output logic [7:0] SCMD,
  output logic       SNMI,
  output logic       PEND,
  output logic       OVF
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(NMI_GAP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_t;

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_d;
  logic                   push;
  logic                   rd_d1, rd_d2;
  logic                   pop_req;
  logic [PW-1:0]          wr_ptr, rd_ptr, wr_next, rd_next;
  logic                   full, empty, do_push, do_pop;
  logic [7:0]             mem [DEPTH];
  logic [7:0]             last_q;
  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;

  // push is a registered edge pulse so the write lands SYNC_STAGES+1 edges after first sample
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      req_sync <= '0;
      req_d    <= 1'b0;
      push     <= 1'b0;
      rd_d1    <= 1'b0;
      rd_d2    <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], SNDRQ};
      req_d    <= req_sync[SYNC_STAGES-1];
      push     <= req_sync[SYNC_STAGES-1] & ~req_d;
      rd_d1    <= SCPU_RD;
      rd_d2    <= rd_d1;
    end
  end

  assign pop_req = rd_d2 & ~rd_d1;
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop_req & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wr_next = wr_ptr + PW'(do_push);
  assign rd_next = rd_ptr + PW'(do_pop);

  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      PEND   <= 1'b0;
      OVF    <= 1'b0;
      last_q <= 8'h00;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      PEND   <= (wr_next != rd_next);
      if (push && full && !do_pop) OVF <= 1'b1;
      if (do_pop) last_q <= mem[rd_ptr[PW-2:0]];
    end
  end

  always_ff @(posedge CLK48M) begin
    if (do_push) mem[wr_ptr[PW-2:0]] <= CMDIN;
  end

  assign SCMD = empty ? last_q : mem[rd_ptr[PW-2:0]];

  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE:   if (PEND) state_next = ST_ASSERT;
      ST_ASSERT: if (do_pop) begin
        state_next = ST_GAP;
        cnt_next   = CW'(NMI_GAP - 1);
      end
      ST_GAP: begin
        if (cnt == '0) state_next = PEND ? ST_ASSERT : ST_IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    SNMI = (state == ST_ASSERT);
  end

endmodule

// File: tb/tb_segasys1_sound_cmd.sv
// Randomised bench for segasys1_sound_cmd against a queue-based command model,
// plus directed latency, NMI-gap, overflow, collision and reset scenarios.
module tb_segasys1_sound_cmd;

  logic       CLK48M = 1'b0;
  logic       RESET_N;
  logic       SNDRQ;
  logic [7:0] CMDIN;
  logic       SCPU_RD;
  logic [7:0] SCMD;
  logic       SNMI, PEND, OVF;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] m_last;

  logic mon_clr = 1'b1;
  logic snmi_prev = 1'b0;
  logic seen_fall = 1'b0;
  int   rises = 0;
  int   low_run = 0;
  int   min_gap = 1000;

  segasys1_sound_cmd #(.DEPTH_LOG2(2), .SYNC_STAGES(2), .NMI_GAP(16)) dut (
    .CLK48M (CLK48M),
    .RESET_N(RESET_N),
    .SNDRQ  (SNDRQ),
    .CMDIN  (CMDIN),
    .SCPU_RD(SCPU_RD),
    .SCMD   (SCMD),
    .SNMI   (SNMI),
    .PEND   (PEND),
    .OVF    (OVF)
  );

  always #5 CLK48M = ~CLK48M;

  // NMI edge counter and minimum low-run between consecutive pulses
  always @(negedge CLK48M) begin
    if (mon_clr) begin
      rises = 0; min_gap = 1000; low_run = 0; seen_fall = 1'b0; snmi_prev = SNMI;
    end else begin
      if (SNMI && !snmi_prev) begin
        rises = rises + 1;
        if (seen_fall && low_run < min_gap) min_gap = low_run;
      end
      if (!SNMI && snmi_prev) seen_fall = 1'b1;
      if (!SNMI) low_run = low_run + 1; else low_run = 0;
      snmi_prev = SNMI;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() == 4) m_ovf = 1'b1;
    else q.push_back(b);
  endtask

  task automatic model_pop();
    if (q.size() != 0) m_last = q.pop_front();
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_last = 8'h00;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] e;
    e = (q.size() != 0) ? q[0] : m_last;
    check({tag, "_pend"}, PEND, (q.size() != 0));
    check({tag, "_scmd"}, SCMD, e);
    check({tag, "_ovf"}, OVF, m_ovf);
  endtask

  task automatic clear_monitor();
    mon_clr = 1'b1;
    @(negedge CLK48M);
    #1 mon_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b, input int len);
    @(negedge CLK48M);
    CMDIN = b;
    SNDRQ = 1'b1;
    repeat (len) @(negedge CLK48M);
    SNDRQ = 1'b0;
    repeat (6) @(negedge CLK48M);
    model_push(b);
  endtask

  task automatic do_read(input int len);
    @(negedge CLK48M);
    SCPU_RD = 1'b1;
    repeat (len) @(negedge CLK48M);
    SCPU_RD = 1'b0;
    repeat (4) @(negedge CLK48M);
    model_pop();
  endtask

  task automatic wait_nmi(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK48M);
      if (SNMI) begin got = 1'b1; break; end
    end
    check(tag, got, 1'b1);
  endtask

  initial begin
    int hi;
    logic [7:0] b;
    RESET_N = 1'b0;
    SNDRQ   = 1'b0;
    SCPU_RD = 1'b0;
    CMDIN   = 8'h00;
    model_reset();
    repeat (3) @(negedge CLK48M);
    RESET_N = 1'b1;
    @(negedge CLK48M);
    check_state("init");
    check("init_snmi", SNMI, 1'b0);
    clear_monitor();

    // single command: push latency and pop latency measured edge by edge
    @(negedge CLK48M);
    CMDIN = 8'hA5;
    SNDRQ = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge CLK48M);
      #1;
      if (k == 0) SNDRQ = 1'b0;
      if (k == 2) check("t2_pend_n2", PEND, 1'b0);
      if (k == 3) begin
        check("t2_pend_n3", PEND, 1'b1);
        check("t2_snmi_n3", SNMI, 1'b0);
      end
      if (k == 4) begin
        check("t2_snmi_n4", SNMI, 1'b1);
        check("t2_scmd", SCMD, 8'hA5);
      end
    end
    model_push(8'hA5);
    @(negedge CLK48M);
    SCPU_RD = 1'b1;
    repeat (4) @(negedge CLK48M);
    SCPU_RD = 1'b0;
    @(posedge CLK48M);
    #1 check("t2_pend_m", PEND, 1'b1);
    @(posedge CLK48M);
    #1;
    check("t2_pend_m1", PEND, 1'b0);
    check("t2_snmi_m1", SNMI, 1'b0);
    check("t2_scmd_hold", SCMD, 8'hA5);
    model_pop();
    hi = 0;
    repeat (16) begin
      @(posedge CLK48M);
      #1 if (SNMI) hi = 1;
    end
    check("t2_nmi_quiet", hi, 0);

    // back-to-back: three queued commands, three NMI edges with full gaps
    clear_monitor();
    send_cmd(8'h11, $urandom_range(1, 3));
    send_cmd(8'h22, $urandom_range(1, 3));
    send_cmd(8'h33, $urandom_range(1, 3));
    check_state("t3_queued");
    for (int i = 0; i < 3; i++) begin
      wait_nmi("t3_nmi_wait");
      check("t3_head", SCMD, q[0]);
      do_read(4);
    end
    repeat (40) @(negedge CLK48M);
    check_state("t3_drained");
    check("t3_scmd33", SCMD, 8'h33);
    check("t3_rises", rises, 3);
    check("t3_gap_ok", (min_gap >= 16), 1'b1);

    // overflow
    for (int i = 1; i <= 5; i++) begin
      send_cmd(8'(i), $urandom_range(1, 4));
      check_state("t4_push");
    end
    check("t4_ovf", OVF, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("t4_rd", SCMD, 8'(i));
      do_read($urandom_range(1, 6));
      check_state("t4_after_rd");
    end
    send_cmd(8'h5A, 2);
    send_cmd(8'h6B, 2);

    // asynchronous reset between clock edges
    @(negedge CLK48M);
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check("rst_scmd", SCMD, 8'h00);
    check("rst_snmi", SNMI, 1'b0);
    check("rst_pend", PEND, 1'b0);
    check("rst_ovf", OVF, 1'b0);
    repeat (2) @(negedge CLK48M);
    RESET_N = 1'b1;

    // collision: push and pop on the same edge while full
    for (int i = 0; i < 4; i++) send_cmd(8'($urandom), $urandom_range(1, 3));
    check_state("t5_full");
    @(negedge CLK48M);
    SCPU_RD = 1'b1;
    repeat (3) @(negedge CLK48M);
    CMDIN = 8'hEE;
    SNDRQ = 1'b1;
    @(negedge CLK48M);
    SNDRQ = 1'b0;
    @(negedge CLK48M);
    SCPU_RD = 1'b0;
    repeat (6) @(negedge CLK48M);
    model_pop();
    model_push(8'hEE);
    check_state("t5_coll");
    for (int i = 0; i < 4; i++) begin
      do_read($urandom_range(1, 5));
      check_state("t5_rd");
    end
    check("t5_last_ee", SCMD, 8'hEE);

    // long request pulse, then read while empty
    send_cmd(8'h77, 40);
    check_state("t6_one");
    do_read(3);
    check_state("t6_empty");
    clear_monitor();
    do_read(3);
    repeat (30) @(negedge CLK48M);
    check_state("t6_idle_rd");
    check("t6_no_nmi", rises, 0);

    // randomised traffic against the queue model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        send_cmd(b, $urandom_range(1, 5));
      end else begin
        do_read($urandom_range(1, 6));
      end
      check_state("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
